// File: rtl/sram_block_loader.sv
// Streams samples into a 32x16 SRAM as 8-word blocks, clearing each block's
// result slot, and holds the processing core in reset until the image is complete.
module sram_block_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] DataIN,
  output logic                  Busy,
  output logic                  Done,
  output logic                  ProcReset
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  proc_rel_q, proc_rel_d;

  logic result_slot;
  logic last_slot;
  logic issue;

  // The last word of every block is the result slot the core fills in later.
  assign result_slot = (ptr_q[OFF_W-1:0] == {OFF_W{1'b1}});
  assign last_slot   = (ptr_q == {ADDR_WIDTH{1'b1}});

  assign InReady = (state_q == LOAD) && !result_slot;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    issue   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (result_slot) begin
          issue  = 1'b1;
          data_d = '0;
        end else if (InValid) begin
          issue  = 1'b1;
          data_d = InData;
        end
        if (issue) begin
          addr_d = ptr_q;
          ptr_d  = ptr_q + ADDR_WIDTH'(1);
          we_d   = 1'b1;
          if (last_slot) state_d = FLUSH;
        end
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Released together with entering DONE, dropped on the same edge as a restart.
    proc_rel_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      proc_rel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      proc_rel_q <= proc_rel_d;
    end
  end

  assign Address     = addr_q;
  assign DataIN      = data_q;
  assign WriteEnable = we_q;
  assign ProcReset   = proc_rel_q;
  assign Busy        = (state_q == LOAD) || (state_q == FLUSH);
  assign Done        = (state_q == DONE);

endmodule
